im_boot_tx: RTL and testbench

//  Transmit side of the instruction-memory boot-load stream. Pops program words from a

---
 rtl/im_boot_pkg.sv | 18 +
 rtl/im_boot_tx_if.sv | 24 ++
 rtl/im_boot_wdog.sv | 29 ++
 rtl/im_boot_tx.sv | 128 ++++++++++++
 tb/tb_im_boot_tx.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/im_boot_pkg.sv
// Shared types and word framing for the instruction-memory boot-load transmitter.
package im_boot_pkg;

  localparam int IM_WORD_W   = 33;
  localparam int IM_LAST_BIT = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [IM_WORD_W-1:0] im_frame(input logic last, input logic [31:0] data);
    return {last, data};
  endfunction

endpackage

// File: rtl/im_boot_tx_if.sv
// Source-FIFO and IM-loader signals of the boot-load transmitter.
interface im_boot_tx_if;
  import im_boot_pkg::*;

  logic [31:0]          SRCdata;
  logic                 SRCempty;
  logic                 SRCrd;
  logic                 STOP;
  logic                 PCstart;
  logic [IM_WORD_W-1:0] WRdata;
  logic                 VALIDin;
  logic                 EMPTY;

  modport master (
    input  SRCdata, SRCempty, STOP, PCstart,
    output SRCrd, WRdata, VALIDin, EMPTY
  );

  modport slave (
    output SRCdata, SRCempty, STOP, PCstart,
    input  SRCrd, WRdata, VALIDin, EMPTY
  );

endinterface

// File: rtl/im_boot_wdog.sv
// FLUSH-phase watchdog: counts cycles while run is high, expires on the TMO_CYC-th cycle.
module im_boot_wdog #(
  parameter int TMO_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int W = $clog2(TMO_CYC + 1);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (run && !expire) begin
      cnt_reg <= cnt_reg + W'(1);
    end
  end

  // cnt_reg holds (cycles already spent in FLUSH), so equality with TMO_CYC-1 marks the last one
  assign expire = run && (cnt_reg == W'(TMO_CYC - 1));

endmodule

// File: rtl/im_boot_tx.sv
// Boot-load transmitter: pops FWFT source words and frames them for the IM loader.
// Optional PCstart timeout enabled by defining IM_BOOT_TIMEOUT_EN.
module im_boot_tx
  import im_boot_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TMO_CYC = 1024
) (
  input  logic             clk,
  input  logic             RSTcount,
  input  logic             START,
  input  logic [CNT_W-1:0] WORDcount,
  im_boot_tx_if.master     bus,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERROR
);

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     remaining_reg, remaining_next;
  logic [IM_WORD_W-1:0] wrdata_reg, wrdata_next;
  logic                 valid_reg, valid_next;
  logic                 empty_reg, empty_next;
  logic                 done_reg, done_next;
  logic                 error_reg, error_next;
  logic                 src_rd;
  logic                 last_word;
  logic                 wdog_expire;

`ifdef IM_BOOT_TIMEOUT_EN
  im_boot_wdog #(.TMO_CYC(TMO_CYC)) u_wdog (
    .clk    (clk),
    .rst    (RSTcount),
    .clear  (state_reg != ST_FLUSH),
    .run    (state_reg == ST_FLUSH),
    .expire (wdog_expire)
  );
`else
  localparam int unused_tmo_cyc = TMO_CYC;
  assign wdog_expire = 1'b0;
`endif

  // STOP gates the pop, so a stop request can never coincide with the final word
  assign src_rd    = (state_reg == ST_LOAD) && !bus.SRCempty && !bus.STOP && (remaining_reg != '0);
  assign last_word = (remaining_reg == CNT_W'(1));

  always_ff @(posedge clk or posedge RSTcount) begin
    if (RSTcount) begin
      state_reg     <= ST_IDLE;
      remaining_reg <= '0;
      wrdata_reg    <= '0;
      valid_reg     <= 1'b0;
      empty_reg     <= 1'b1;
      done_reg      <= 1'b0;
      error_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      wrdata_reg    <= wrdata_next;
      valid_reg     <= valid_next;
      empty_reg     <= empty_next;
      done_reg      <= done_next;
      error_reg     <= error_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    wrdata_next    = wrdata_reg;
    valid_next     = 1'b0;
    empty_next     = empty_reg;
    done_next      = done_reg;
    error_next     = error_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          remaining_next = WORDcount;
          done_next      = 1'b0;
          error_next     = 1'b0;
          if (WORDcount == '0) begin
            state_next = ST_FLUSH;
          end else begin
            empty_next = 1'b0;
            state_next = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (bus.STOP && (remaining_reg != '0)) begin
          error_next = 1'b1;
          empty_next = 1'b1;
          state_next = ST_FLUSH;
        end else if (src_rd) begin
          wrdata_next    = im_frame(last_word, bus.SRCdata);
          valid_next     = 1'b1;
          remaining_next = remaining_reg - CNT_W'(1);
          if (last_word) begin
            empty_next = 1'b1;
            state_next = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        empty_next = 1'b1;
        // PCstart on the terminal watchdog cycle takes priority over the timeout
        if (bus.PCstart) begin
          done_next  = 1'b1;
          state_next = ST_DONE;
        end else if (wdog_expire) begin
          done_next  = 1'b1;
          error_next = 1'b1;
          state_next = ST_DONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.SRCrd   = src_rd;
  assign bus.WRdata  = wrdata_reg;
  assign bus.VALIDin = valid_reg;
  assign bus.EMPTY   = empty_reg;
  assign BUSY        = (state_reg == ST_LOAD) || (state_reg == ST_FLUSH);
  assign DONE        = done_reg;
  assign ERROR       = error_reg;

endmodule

// File: tb/tb_im_boot_tx.sv
// Directed scoreboard bench for im_boot_tx; the timeout case runs when IM_BOOT_TIMEOUT_EN is defined.
module tb_im_boot_tx;

  logic        clk = 1'b0;
  logic        RSTcount;
  logic        START;
  logic [15:0] WORDcount;
  logic        BUSY, DONE, ERROR;

  im_boot_tx_if bus();

  im_boot_tx #(.CNT_W(16), .TMO_CYC(16)) dut (
    .clk       (clk),
    .RSTcount  (RSTcount),
    .START     (START),
    .WORDcount (WORDcount),
    .bus       (bus),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .ERROR     (ERROR)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] src_q[$];
  logic [32:0] sb_q[$];
  int          valid_cyc[$];
  int          valid_cnt = 0;
  int          pops = 0;
  int          cyc = 0;
  logic        pop_now = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic src_refresh();
    bus.SRCempty = (src_q.size() == 0);
    bus.SRCdata  = (src_q.size() == 0) ? 32'h0 : src_q[0];
  endtask

  task automatic push_word(input logic [31:0] w);
    src_q.push_back(w);
    src_refresh();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input int n);
    WORDcount = 16'(n);
    START = 1'b1;
    step();
    START = 1'b0;
  endtask

  task automatic pcstart_pulse();
    bus.PCstart = 1'b1;
    step();
    bus.PCstart = 1'b0;
  endtask

  task automatic wait_valid(input int target, input int budget);
    int k = 0;
    while (valid_cnt < target && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (valid_cnt < target) chk("wait_valid_timeout", 64'(valid_cnt), 64'(target));
  endtask

  // Source FIFO model: the pop decision is sampled mid-cycle, the queue advances just after the edge
  always @(negedge clk) pop_now = bus.SRCrd;

  always @(posedge clk) begin
    #1;
    if (pop_now) begin
      chk("pop_nonempty", 64'(src_q.size() > 0), 64'd1);
      if (src_q.size() > 0) void'(src_q.pop_front());
      pops++;
    end
    src_refresh();
  end

  // Output monitor: each VALIDin pulse is matched against the scoreboard
  always @(negedge clk) begin
    logic [32:0] exp_w;
    cyc++;
    if (!RSTcount && bus.VALIDin) begin
      if (sb_q.size() == 0) begin
        chk("sb_underrun", 64'd1, 64'd0);
      end else begin
        exp_w = sb_q.pop_front();
        chk("wrdata", 64'(bus.WRdata), 64'(exp_w));
        chk("empty_vs_last", 64'(bus.EMPTY), 64'(exp_w[32]));
        $display("word %0d: WRdata=%09h expected=%09h", valid_cnt, bus.WRdata, exp_w);
      end
      valid_cyc.push_back(cyc);
      valid_cnt++;
    end
  end

  initial begin
    int base_v;
    int base_p;
    int n;

    RSTcount    = 1'b1;
    START       = 1'b0;
    WORDcount   = '0;
    bus.STOP    = 1'b0;
    bus.PCstart = 1'b0;
    src_refresh();

    step();
    chk("rst_wrdata", 64'(bus.WRdata), 64'd0);
    chk("rst_valid", 64'(bus.VALIDin), 64'd0);
    chk("rst_empty", 64'(bus.EMPTY), 64'd1);
    chk("rst_srcrd", 64'(bus.SRCrd), 64'd0);
    chk("rst_busy", 64'(BUSY), 64'd0);
    chk("rst_done", 64'(DONE), 64'd0);
    chk("rst_error", 64'(ERROR), 64'd0);
    RSTcount = 1'b0;
    step();

    // 4 words back to back; last flag only on the fourth
    base_v = valid_cnt; base_p = pops;
    for (int i = 0; i < 4; i++) begin
      push_word(32'hA0 + 32'(i));
      sb_q.push_back({(i == 3), 32'hA0 + 32'(i)});
    end
    start_load(4);
    chk("t2_busy_load", 64'(BUSY), 64'd1);
    chk("t2_empty_load", 64'(bus.EMPTY), 64'd0);
    wait_valid(base_v + 4, 20);
    n = valid_cyc.size();
    chk("t2_back_to_back", 64'(valid_cyc[n-1] - valid_cyc[n-4]), 64'd3);
    chk("t2_pops", 64'(pops - base_p), 64'd4);
    chk("t2_flush_busy", 64'(BUSY), 64'd1);
    chk("t2_flush_done", 64'(DONE), 64'd0);
    step();
    chk("t2_valid_ends", 64'(bus.VALIDin), 64'd0);
    pcstart_pulse();
    chk("t2_done", 64'(DONE), 64'd1);
    chk("t2_error", 64'(ERROR), 64'd0);
    chk("t2_idle_busy", 64'(BUSY), 64'd0);
    chk("t2_empty", 64'(bus.EMPTY), 64'd1);

    // 3 words with the source running dry for 2 cycles after the first
    base_v = valid_cnt; base_p = pops;
    push_word(32'hB0);
    sb_q.push_back({1'b0, 32'hB0});
    sb_q.push_back({1'b0, 32'hB1});
    sb_q.push_back({1'b1, 32'hB2});
    start_load(3);
    wait_valid(base_v + 1, 20);
    step();
    step();
    push_word(32'hB1);
    push_word(32'hB2);
    push_word(32'hB3);
    wait_valid(base_v + 3, 20);
    n = valid_cyc.size();
    chk("t3_gap", 64'(valid_cyc[n-2] - valid_cyc[n-3]), 64'd3);
    chk("t3_after_gap", 64'(valid_cyc[n-1] - valid_cyc[n-2]), 64'd1);
    repeat (3) step();
    chk("t3_pops", 64'(pops - base_p), 64'd3);
    chk("t3_leftover", 64'(src_q.size()), 64'd1);
    pcstart_pulse();
    chk("t3_done", 64'(DONE), 64'd1);
    src_q.delete();
    src_refresh();

    // 8 words requested, STOP after the 5th
    base_v = valid_cnt; base_p = pops;
    for (int i = 0; i < 5; i++) begin
      push_word(32'hC0 + 32'(i));
      sb_q.push_back({1'b0, 32'hC0 + 32'(i)});
    end
    start_load(8);
    wait_valid(base_v + 5, 20);
    step();
    bus.STOP = 1'b1;
    for (int i = 5; i < 8; i++) push_word(32'hC0 + 32'(i));
    repeat (3) step();
    chk("t4_pops", 64'(pops - base_p), 64'd5);
    chk("t4_error", 64'(ERROR), 64'd1);
    chk("t4_empty", 64'(bus.EMPTY), 64'd1);
    chk("t4_busy", 64'(BUSY), 64'd1);
    chk("t4_stop_holds_flush", 64'(DONE), 64'd0);
    bus.STOP = 1'b0;
    pcstart_pulse();
    chk("t4_done", 64'(DONE), 64'd1);
    chk("t4_error_sticky", 64'(ERROR), 64'd1);
    chk("t4_no_extra_pops", 64'(pops - base_p), 64'd5);
    src_q.delete();
    src_refresh();

    // zero-length load, START while busy ignored
    base_v = valid_cnt; base_p = pops;
    start_load(0);
    chk("t5_error_cleared", 64'(ERROR), 64'd0);
    chk("t5_done_cleared", 64'(DONE), 64'd0);
    chk("t5_busy", 64'(BUSY), 64'd1);
    chk("t5_empty", 64'(bus.EMPTY), 64'd1);
    push_word(32'hD0);
    start_load(5);
    repeat (3) step();
    chk("t5_ignored_pops", 64'(pops - base_p), 64'd0);
    chk("t5_ignored_empty", 64'(bus.EMPTY), 64'd1);
    chk("t5_no_valid", 64'(valid_cnt - base_v), 64'd0);
    pcstart_pulse();
    chk("t5_done", 64'(DONE), 64'd1);
    chk("t5_error", 64'(ERROR), 64'd0);
    src_q.delete();
    src_refresh();

`ifdef IM_BOOT_TIMEOUT_EN
    // PCstart withheld: timeout on the 16th FLUSH cycle
    base_v = valid_cnt;
    push_word(32'hF0);
    sb_q.push_back({1'b1, 32'hF0});
    start_load(1);
    wait_valid(base_v + 1, 20);
    repeat (15) step();
    chk("t6_cycle16_done", 64'(DONE), 64'd0);
    chk("t6_cycle16_busy", 64'(BUSY), 64'd1);
    step();
    chk("t6_tmo_done", 64'(DONE), 64'd1);
    chk("t6_tmo_error", 64'(ERROR), 64'd1);
    chk("t6_tmo_busy", 64'(BUSY), 64'd0);

    // PCstart on the terminal cycle wins
    base_v = valid_cnt;
    push_word(32'hF1);
    sb_q.push_back({1'b1, 32'hF1});
    start_load(1);
    wait_valid(base_v + 1, 20);
    repeat (15) step();
    pcstart_pulse();
    chk("t6_pc_done", 64'(DONE), 64'd1);
    chk("t6_pc_error", 64'(ERROR), 64'd0);
`endif

    // asynchronous reset in the middle of a load
    base_v = valid_cnt;
    push_word(32'hE0);
    push_word(32'hE1);
    sb_q.push_back({1'b0, 32'hE0});
    sb_q.push_back({1'b0, 32'hE1});
    start_load(4);
    wait_valid(base_v + 2, 20);
    chk("t1_pre_valid", 64'(bus.VALIDin), 64'd1);
    RSTcount = 1'b1;
    #1;
    chk("t1_wrdata", 64'(bus.WRdata), 64'd0);
    chk("t1_valid", 64'(bus.VALIDin), 64'd0);
    chk("t1_empty", 64'(bus.EMPTY), 64'd1);
    chk("t1_srcrd", 64'(bus.SRCrd), 64'd0);
    chk("t1_busy", 64'(BUSY), 64'd0);
    chk("t1_done", 64'(DONE), 64'd0);
    chk("t1_error", 64'(ERROR), 64'd0);
    step();
    RSTcount = 1'b0;
    step();
    chk("t1_stays_idle", 64'(BUSY), 64'd0);
    chk("t1_sb_drained", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
